// File: rtl/cla_serial_addsub_pkg.sv
// Shared types and elaboration helpers for the serial carry-lookahead adder/subtractor.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  // A single-group datapath still needs a 1-bit index register.
  function automatic int idx_width(input int ngroups);
    return (clog2(ngroups) < 1) ? 1 : clog2(ngroups);
  endfunction

endpackage

// File: rtl/cla_serial_addsub_group.sv
// Combinational GROUP-bit carry-lookahead slice with flattened carry equations.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb,
  output logic             grp_p,
  output logic             grp_g
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             g_acc;
  logic             p_run;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a sum of products over all lower bits, not a ripple chain.
  always_comb begin
    c     = '0;
    g_acc = 1'b0;
    p_run = 1'b1;
    c[0]  = cin;
    for (int i = 0; i < GROUP; i++) begin
      g_acc = 1'b0;
      p_run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        g_acc = g_acc | (g[j] & p_run);
        p_run = p_run & p[j];
      end
      c[i+1] = g_acc | (cin & p_run);
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];
  assign grp_p = &p;
  assign grp_g = g_acc;

endmodule

// File: rtl/cla_serial_addsub.sv
// Multi-cycle adder/subtractor: one CLA group resolved per clock, LSB group first.
module cla_serial_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUPS = WIDTH / GROUP;
  localparam int IDXW    = idx_width(NGROUPS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NGROUPS - 1);

  generate
    if ((WIDTH % GROUP) != 0) begin : g_bad_width
      $error("cla_serial_addsub: WIDTH must be a multiple of GROUP");
    end
    if (GROUP < 1 || GROUP > 8) begin : g_bad_group
      $error("cla_serial_addsub: GROUP must be in 1..8");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [GROUP-1:0] grp_a;
  logic [GROUP-1:0] grp_b;
  logic [GROUP-1:0] grp_sum;
  logic             grp_cout;
  logic             grp_c_msb;
  logic             grp_p;
  logic             grp_g;

  assign grp_a = a_q[idx_q*GROUP +: GROUP];
  assign grp_b = b_q[idx_q*GROUP +: GROUP];

  cla_group #(
    .GROUP (GROUP)
  ) u_group (
    .a     (grp_a),
    .b     (grp_b),
    .cin   (carry_q),
    .sum   (grp_sum),
    .cout  (grp_cout),
    .c_msb (grp_c_msb),
    .grp_p (grp_p),
    .grp_g (grp_g)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the +1 rides in on the carry register.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*GROUP +: GROUP] = grp_sum;
        carry_d = grp_g | (grp_p & carry_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = grp_cout;
          ovf_d   = grp_c_msb ^ grp_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Directed and random checks of cla_serial_addsub against an integer-arithmetic model.
module tb_cla_serial_addsub;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;

  cla_serial_addsub #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic, result packed as {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    int          sr;
    int          ur;
    logic        mcout;
    logic        movf;
    logic [15:0] msum;
    if (msub) begin
      sr    = int'($signed(ma)) - int'($signed(mb));
      ur    = int'(ma) - int'(mb);
      mcout = (ma >= mb);
    end else begin
      sr    = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
      ur    = int'(ma) + int'(mb) + int'(mcin);
      mcout = (ur > 65535);
    end
    movf = (sr > 32767) || (sr < -32768);
    msum = ur[15:0];
    return {movf, mcout, msum};
  endfunction

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_in, input logic tc,
                       input logic ts, input int hold);
    logic [17:0] exp;
    int          n;
    exp = model(ta, tb_in, tc, ts);
    @(negedge clk);
    a = ta; b = tb_in; cin = tc; sub = ts; in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(NGROUPS));
    chk("sum", 32'(sum), 32'(exp[15:0]));
    chk("cout", 32'(cout), 32'(exp[16]));
    chk("ovf", 32'(ovf), 32'(exp[17]));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", {13'd0, ovf, cout, sum}, {14'd0, exp});
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("back_idle", 32'(in_ready), 32'd1);
    $display("op a=%04h b=%04h cin=%0d sub=%0d -> sum=%04h cout=%0d ovf=%0d", ta, tb_in, tc, ts,
             exp[15:0], exp[16], exp[17]);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out", {28'd0, out_valid, cout, ovf, |sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 5);

    // Reset during the second RUN cycle discards the in-flight operation.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out", {28'd0, out_valid, cout, ovf, |sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end
    $display("reset mid-run: outputs cleared, no result emitted");
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
